// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller.
// Floor indices are 3 bits wide, so bitmaps are handled as 8-bit vectors internally.
package elevator_pkg;

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} car_state_t;

    localparam int unsigned FLOOR_W    = 3;
    localparam int unsigned MAX_FLOORS = 1 << FLOOR_W;

    typedef struct packed {
        logic above;
        logic below;
    } scan_flags_t;

    // Pending requests strictly above / strictly below the given floor.
    function automatic scan_flags_t scan_flags(input logic [MAX_FLOORS-1:0] bitmap,
                                               input logic [FLOOR_W-1:0]    floor);
        scan_flags_t f;
        f.above = |(bitmap & (8'hFE << floor));
        f.below = |(bitmap & ~(8'hFF << floor));
        return f;
    endfunction

endpackage

// File: rtl/elevator_countdown.sv
// Loadable down-counter that saturates at zero; used for travel and door timing.
module elevator_countdown #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Car-level SCAN scheduler: owns the queue write port, tracks car position
// and sequences the door. Floor-clear writes take priority over call writes.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned FLOOR_COUNT         = 7,
    parameter int unsigned FLOOR_TRAVEL_CYCLES = 16,
    parameter int unsigned DOOR_OPEN_CYCLES    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   call_valid,
    input  logic [FLOOR_W-1:0]     call_floor,
    output logic                   call_ready,
    input  logic [FLOOR_COUNT-1:0] queue_status,
    output logic                   q_r_nwr,
    output logic                   q_deassert_floor,
    output logic [FLOOR_W-1:0]     q_requested_floor,
    output logic [FLOOR_W-1:0]     current_floor,
    output logic                   dir_up,
    output logic                   moving,
    output logic                   door_open
);

    localparam int unsigned TRAVEL_W = $clog2(FLOOR_TRAVEL_CYCLES);
    localparam int unsigned DOOR_W   = $clog2(DOOR_OPEN_CYCLES);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOOR_COUNT - 1);

    car_state_t            state, state_n;
    logic [FLOOR_W-1:0]    floor_n, arr_floor, step_floor;
    logic                  dir_n;
    logic                  travel_load, travel_zero, door_load, door_zero;
    logic                  clear_req, call_in_range, here;
    logic [MAX_FLOORS-1:0] qs_ext;
    scan_flags_t           flags;

    elevator_countdown #(.WIDTH(TRAVEL_W)) u_travel (
        .clk        (clk),
        .reset      (reset),
        .load       (travel_load),
        .load_value (TRAVEL_W'(FLOOR_TRAVEL_CYCLES - 1)),
        .zero       (travel_zero)
    );

    elevator_countdown #(.WIDTH(DOOR_W)) u_door (
        .clk        (clk),
        .reset      (reset),
        .load       (door_load),
        .load_value (DOOR_W'(DOOR_OPEN_CYCLES - 1)),
        .zero       (door_zero)
    );

    // Floor the decision is made on: the arrival floor on the last travel cycle.
    always_comb begin
        if (dir_up) begin
            step_floor = (current_floor == TOP_FLOOR) ? current_floor : current_floor + FLOOR_W'(1);
        end else begin
            step_floor = (current_floor == '0) ? current_floor : current_floor - FLOOR_W'(1);
        end
        arr_floor = (state == MOVING && travel_zero) ? step_floor : current_floor;
        qs_ext = '0;
        qs_ext[FLOOR_COUNT-1:0] = queue_status;
        here  = qs_ext[arr_floor];
        flags = scan_flags(qs_ext, arr_floor);
    end

    always_comb begin
        state_n     = state;
        floor_n     = arr_floor;
        dir_n       = dir_up;
        clear_req   = 1'b0;
        travel_load = 1'b0;
        door_load   = 1'b0;
        unique case (state)
            IDLE: begin
                if (here) begin
                    clear_req = 1'b1;
                    door_load = 1'b1;
                    state_n   = DOOR_OPEN;
                end else if (flags.above || flags.below) begin
                    if (dir_up ? !flags.above : !flags.below) begin
                        dir_n = !dir_up;
                    end
                    travel_load = 1'b1;
                    state_n     = MOVING;
                end
            end
            MOVING: begin
                if (travel_zero) begin
                    if (here) begin
                        clear_req = 1'b1;
                        door_load = 1'b1;
                        state_n   = DOOR_OPEN;
                    end else if (dir_up ? flags.above : flags.below) begin
                        travel_load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                if (here) begin
                    clear_req = 1'b1;
                    door_load = 1'b1;
                end else if (door_zero) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign call_ready    = !clear_req;
    assign call_in_range = ({1'b0, call_floor} < (FLOOR_W + 1)'(FLOOR_COUNT));

    always_comb begin
        q_r_nwr           = 1'b1;
        q_deassert_floor  = 1'b0;
        q_requested_floor = '0;
        if (clear_req) begin
            q_r_nwr           = 1'b0;
            q_deassert_floor  = 1'b1;
            q_requested_floor = arr_floor;
        end else if (call_valid && call_in_range) begin
            q_r_nwr           = 1'b0;
            q_requested_floor = call_floor;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            current_floor <= '0;
            dir_up        <= 1'b1;
        end else begin
            state         <= state_n;
            current_floor <= floor_n;
            dir_up        <= dir_n;
        end
    end

    assign moving    = (state == MOVING);
    assign door_open = (state == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with a behavioural pending-floor queue
// attached to its write port; timings assume 16-cycle travel and 8-cycle door.
module tb_elevator_scheduler;

    logic       clk;
    logic       reset;
    logic       call_valid;
    logic [2:0] call_floor;
    logic       call_ready;
    logic [6:0] queue_status;
    logic       q_r_nwr;
    logic       q_deassert_floor;
    logic [2:0] q_requested_floor;
    logic [2:0] current_floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;

    int checks = 0;
    int errors = 0;

    elevator_scheduler #(
        .FLOOR_COUNT         (7),
        .FLOOR_TRAVEL_CYCLES (16),
        .DOOR_OPEN_CYCLES    (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .call_valid        (call_valid),
        .call_floor        (call_floor),
        .call_ready        (call_ready),
        .queue_status      (queue_status),
        .q_r_nwr           (q_r_nwr),
        .q_deassert_floor  (q_deassert_floor),
        .q_requested_floor (q_requested_floor),
        .current_floor     (current_floor),
        .dir_up            (dir_up),
        .moving            (moving),
        .door_open         (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pending-floor queue: one write port, reset together with the scheduler.
    logic [6:0] qmodel;
    always_ff @(posedge clk) begin
        if (reset) begin
            qmodel <= '0;
        end else if (!q_r_nwr && q_requested_floor < 3'd7) begin
            qmodel[q_requested_floor] <= !q_deassert_floor;
        end
    end
    assign queue_status = qmodel;

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_clear(input string tag, input logic [2:0] floor);
        check({tag, "_nwr"},   32'(q_r_nwr), 32'd0);
        check({tag, "_deass"}, 32'(q_deassert_floor), 32'd1);
        check({tag, "_idx"},   32'(q_requested_floor), 32'(floor));
        check({tag, "_ready"}, 32'(call_ready), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        call_valid = 1'b0;
        call_floor = 3'd0;
        step(2);
        reset = 1'b0;
        #1;
        check("rst_floor", 32'(current_floor), 32'd0);
        check("rst_dir",   32'(dir_up), 32'd1);
        check("rst_mov",   32'(moving), 32'd0);
        check("rst_door",  32'(door_open), 32'd0);
        check("rst_nwr",   32'(q_r_nwr), 32'd1);
        check("rst_deass", 32'(q_deassert_floor), 32'd0);
        check("rst_idx",   32'(q_requested_floor), 32'd0);
        check("rst_ready", 32'(call_ready), 32'd1);

        // Call floor 3 from floor 0.
        call_valid = 1'b1;
        call_floor = 3'd3;
        #1;
        check("c3_ready", 32'(call_ready), 32'd1);
        check("c3_nwr",   32'(q_r_nwr), 32'd0);
        check("c3_deass", 32'(q_deassert_floor), 32'd0);
        check("c3_idx",   32'(q_requested_floor), 32'd3);
        step(1);
        call_valid = 1'b0;
        check("c3_qs", 32'(queue_status), 32'h08);
        check("c3_idle_mov", 32'(moving), 32'd0);
        step(1);
        check("c3_start_mov", 32'(moving), 32'd1);
        step(15);
        check("c3_f0_hold", 32'(current_floor), 32'd0);
        step(1);
        check("c3_f1", 32'(current_floor), 32'd1);
        step(16);
        check("c3_f2", 32'(current_floor), 32'd2);
        step(15);
        check_clear("c3_arr", 3'd3);
        step(1);
        check("c3_f3",      32'(current_floor), 32'd3);
        check("c3_door",    32'(door_open), 32'd1);
        check("c3_mov_off", 32'(moving), 32'd0);
        check("c3_qs_clr",  32'(queue_status), 32'h00);
        step(7);
        check("c3_door_last", 32'(door_open), 32'd1);
        step(1);
        check("c3_door_shut", 32'(door_open), 32'd0);
        check("c3_dir",       32'(dir_up), 32'd1);

        // Calls to 5 then 1: serve 5 going up, then reverse to 1.
        call_valid = 1'b1;
        call_floor = 3'd5;
        #1;
        check("s2_c5_ready", 32'(call_ready), 32'd1);
        step(1);
        call_floor = 3'd1;
        #1;
        check("s2_c1_ready", 32'(call_ready), 32'd1);
        check("s2_c1_idx",   32'(q_requested_floor), 32'd1);
        step(1);
        call_valid = 1'b0;
        check("s2_mov", 32'(moving), 32'd1);
        check("s2_dir", 32'(dir_up), 32'd1);
        check("s2_qs",  32'(queue_status), 32'h22);
        step(16);
        check("s2_f4", 32'(current_floor), 32'd4);
        step(16);
        check("s2_f5",      32'(current_floor), 32'd5);
        check("s2_f5_door", 32'(door_open), 32'd1);
        check("s2_f5_qs",   32'(queue_status), 32'h02);
        step(8);
        check("s2_f5_shut", 32'(door_open), 32'd0);
        check("s2_dir_hold", 32'(dir_up), 32'd1);
        step(1);
        check("s2_rev_mov", 32'(moving), 32'd1);
        check("s2_rev_dir", 32'(dir_up), 32'd0);
        step(16);
        check("s2_f4_down", 32'(current_floor), 32'd4);
        step(48);
        check("s2_f1",      32'(current_floor), 32'd1);
        check("s2_f1_door", 32'(door_open), 32'd1);
        check("s2_f1_dir",  32'(dir_up), 32'd0);
        step(8);
        check("s2_f1_shut", 32'(door_open), 32'd0);
        check("s2_qs_empty", 32'(queue_status), 32'h00);

        // Call the current floor while idle at 0.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("s3_floor", 32'(current_floor), 32'd0);
        call_valid = 1'b1;
        call_floor = 3'd0;
        #1;
        check("s3_ready", 32'(call_ready), 32'd1);
        check("s3_nwr",   32'(q_r_nwr), 32'd0);
        step(1);
        call_valid = 1'b0;
        check_clear("s3_clr", 3'd0);
        check("s3_door_pre", 32'(door_open), 32'd0);
        step(1);
        check("s3_door", 32'(door_open), 32'd1);
        check("s3_qs",   32'(queue_status), 32'h00);
        step(8);
        check("s3_shut", 32'(door_open), 32'd0);

        // Re-open: call floor 2 again while the door is open at 2.
        call_valid = 1'b1;
        call_floor = 3'd2;
        step(1);
        call_valid = 1'b0;
        step(1);
        check("s4_mov", 32'(moving), 32'd1);
        step(32);
        check("s4_f2",   32'(current_floor), 32'd2);
        check("s4_door", 32'(door_open), 32'd1);
        step(2);
        call_valid = 1'b1;
        call_floor = 3'd2;
        #1;
        check("s4_ready", 32'(call_ready), 32'd1);
        check("s4_deass", 32'(q_deassert_floor), 32'd0);
        step(1);
        call_valid = 1'b0;
        check_clear("s4_reclr", 3'd2);
        check("s4_qs_set", 32'(queue_status), 32'h04);
        step(1);
        check("s4_qs_clr", 32'(queue_status), 32'h00);
        step(7);
        check("s4_door_ext", 32'(door_open), 32'd1);
        step(1);
        check("s4_shut", 32'(door_open), 32'd0);

        // Call held across an arrival clear.
        call_valid = 1'b1;
        call_floor = 3'd3;
        step(1);
        call_valid = 1'b0;
        step(1);
        check("s5_mov", 32'(moving), 32'd1);
        step(15);
        call_valid = 1'b1;
        call_floor = 3'd6;
        #1;
        check_clear("s5_arr", 3'd3);
        step(1);
        check("s5_f3",    32'(current_floor), 32'd3);
        check("s5_door",  32'(door_open), 32'd1);
        check("s5_qs0",   32'(queue_status), 32'h00);
        check("s5_ready", 32'(call_ready), 32'd1);
        check("s5_nwr",   32'(q_r_nwr), 32'd0);
        check("s5_idx",   32'(q_requested_floor), 32'd6);
        step(1);
        call_valid = 1'b0;
        check("s5_qs6", 32'(queue_status), 32'h40);
        step(7);
        check("s5_shut", 32'(door_open), 32'd0);
        step(1);
        check("s5_go", 32'(moving), 32'd1);
        step(48);
        check("s5_f6",      32'(current_floor), 32'd6);
        check("s5_f6_door", 32'(door_open), 32'd1);
        check("s5_f6_qs",   32'(queue_status), 32'h00);
        step(8);
        check("s5_f6_shut", 32'(door_open), 32'd0);

        // Reset mid-travel between 5 and 4, then an out-of-range call.
        call_valid = 1'b1;
        call_floor = 3'd4;
        step(1);
        call_valid = 1'b0;
        step(1);
        check("s6_mov", 32'(moving), 32'd1);
        check("s6_dir", 32'(dir_up), 32'd0);
        step(16);
        check("s6_f5", 32'(current_floor), 32'd5);
        step(8);
        check("s6_mid", 32'(moving), 32'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("s6_floor", 32'(current_floor), 32'd0);
        check("s6_mov0",  32'(moving), 32'd0);
        check("s6_door0", 32'(door_open), 32'd0);
        check("s6_dir1",  32'(dir_up), 32'd1);
        check("s6_qs",    32'(queue_status), 32'h00);
        call_valid = 1'b1;
        call_floor = 3'd7;
        #1;
        check("s6_c7_ready", 32'(call_ready), 32'd1);
        check("s6_c7_nwr",   32'(q_r_nwr), 32'd1);
        step(1);
        call_valid = 1'b0;
        check("s6_c7_qs", 32'(queue_status), 32'h00);
        step(2);
        check("s6_idle_mov",  32'(moving), 32'd0);
        check("s6_idle_door", 32'(door_open), 32'd0);
        check("s6_idle_floor", 32'(current_floor), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
